// File: rtl/demux_stream_router.sv
// Per-channel FIFO: one synchronous buffer behind one output of the router.
// Latency: a word pushed at edge N is the head at out of this FIFO after edge N.
// Backpressure: push is dropped when full (the top keeps in_ready low); pop ignored when empty.
module demux_stream_router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count
);
    localparam int PW = CW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Fullness gates the push on its own: a pop in the same cycle never
    // frees a slot for a simultaneous push.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Write pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy is the single source of truth for full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is read straight out of storage; no output register.
    assign head_data = mem[rd_ptr];

endmodule

// Buffered 1:4 stream demultiplexer: each accepted word goes to the FIFO named by in_sel.
// Latency: 1 cycle from input handshake to out_valid/out_data on the addressed channel.
// Backpressure: in_ready drops only when the addressed channel is full; each output stalls alone.
module demux_stream_router #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_sel,
    input  logic [DATA_W-1:0]   in_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [4*($clog2(DEPTH)+1)-1:0] out_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] cnt [4];
    logic          push_acc;

    // Ready depends only on the addressed channel's occupancy, never on in_valid.
    assign in_ready = rst_n && (cnt[in_sel] != CW'(DEPTH));
    assign push_acc = in_valid && in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        logic              ch_push;
        logic              ch_pop;
        logic [DATA_W-1:0] ch_head;

        assign ch_push = push_acc && (in_sel == 2'(k));
        assign ch_pop  = out_valid[k] && out_ready[k];

        demux_stream_router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CW     (CW)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (ch_push),
            .push_data (in_data),
            .pop       (ch_pop),
            .head_data (ch_head),
            .count     (cnt[k])
        );

        assign out_valid[k]                 = (cnt[k] != '0);
        assign out_data[k*DATA_W +: DATA_W] = ch_head;
        assign out_count[k*CW +: CW]        = cnt[k];
    end

endmodule
